// File: rtl/fetch_stage.sv
// IF-stage PC generator feeding the 4KB instruction memory, plus the IF/ID side-band register.
// Latency: pc_fetch -> pc_id/valid_id is 1 cycle, lined up with the registered instruction word.
// Backpressure: pipe.stall holds PC and IF/ID; redirects win over stall. `define FETCH_BTB_EN adds a BTB.

package fetch_stage_pkg;
  typedef struct packed {
    logic stall;
    logic flush;
  } PipeControl;
endpackage

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  PipeControl  pipe,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        icache_error,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic [31:0] pc_fetch,
  output logic [31:0] pc_id,
  output logic        valid_id,
  output logic        fetch_error_id,
  output logic        pred_taken_id
);

  typedef enum logic {RUN, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic        valid_id_q, valid_id_d;
  logic        err_id_q, err_id_d;
  logic        pred_id_q, pred_id_d;

  logic        hit;
  logic [31:0] hit_tgt;

`ifdef FETCH_BTB_EN
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [BTB_ENTRIES-1:0] btb_vld_q, btb_vld_d;
  logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
  logic [TAG_W-1:0]       btb_tag_d [BTB_ENTRIES];
  logic [31:0]            btb_tgt_q [BTB_ENTRIES];
  logic [31:0]            btb_tgt_d [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             unused_upd_lsb;

  assign lk_idx         = pc_q[IDX_W+1:2];
  assign lk_tag         = pc_q[31:IDX_W+2];
  assign up_idx         = upd_pc[IDX_W+1:2];
  assign up_tag         = upd_pc[31:IDX_W+2];
  assign unused_upd_lsb = ^upd_pc[1:0];

  // Lookup reads registered contents, so a same-cycle update is seen next cycle.
  assign hit     = btb_vld_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
  assign hit_tgt = btb_tgt_q[lk_idx];

  // BTB write: taken installs/refreshes, not-taken invalidates only a matching tag.
  always_comb begin
    btb_vld_d = btb_vld_q;
    btb_tag_d = btb_tag_q;
    btb_tgt_d = btb_tgt_q;
    if (upd_valid) begin
      if (upd_taken) begin
        btb_vld_d[up_idx] = 1'b1;
        btb_tag_d[up_idx] = up_tag;
        btb_tgt_d[up_idx] = upd_target;
      end else if (btb_tag_q[up_idx] == up_tag) begin
        btb_vld_d[up_idx] = 1'b0;
      end
    end
  end

  // Only the valid bits need a reset; tag/target are qualified by them.
  always_ff @(posedge clk) begin
    if (rst) btb_vld_q <= '0;
    else     btb_vld_q <= btb_vld_d;
  end

  // Tag/target storage.
  always_ff @(posedge clk) begin
    btb_tag_q <= btb_tag_d;
    btb_tgt_q <= btb_tgt_d;
  end
`else
  logic unused_upd;

  assign hit        = 1'b0;
  assign hit_tgt    = 32'h0;
  assign unused_upd = ^{upd_valid, upd_pc, upd_target, upd_taken, BTB_ENTRIES[0]};
`endif

  // Next PC and RUN/HALT: redirect > stall > HALT > prediction > pc+4.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = RUN;
    end else if (pipe.stall) begin
      pc_d = pc_q;
    end else if (state_q == HALT) begin
      pc_d = pc_q;
    end else begin
      pc_d = hit ? hit_tgt : pc_q + 32'd4;
      // A fault under flush is dropped here and re-evaluated next cycle.
      if (icache_error && !pipe.flush) state_d = HALT;
    end
  end

  // IF/ID side-band: stall holds, flush bubbles, otherwise capture the current fetch.
  always_comb begin
    pc_id_d    = pc_id_q;
    valid_id_d = valid_id_q;
    err_id_d   = err_id_q;
    pred_id_d  = pred_id_q;
    if (pipe.stall) begin
      pc_id_d = pc_id_q;
    end else if (pipe.flush) begin
      pc_id_d    = 32'h0;
      valid_id_d = 1'b0;
      err_id_d   = 1'b0;
      pred_id_d  = 1'b0;
    end else begin
      pc_id_d    = pc_q;
      valid_id_d = (state_q == RUN);
      err_id_d   = icache_error && (state_q == RUN);
      pred_id_d  = hit && (state_q == RUN);
    end
  end

  // State registers; reset beats stall and redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      pc_id_q    <= 32'h0;
      valid_id_q <= 1'b0;
      err_id_q   <= 1'b0;
      pred_id_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_id_q    <= pc_id_d;
      valid_id_q <= valid_id_d;
      err_id_q   <= err_id_d;
      pred_id_q  <= pred_id_d;
    end
  end

  assign pc_fetch       = pc_q;
  assign pc_id          = pc_id_q;
  assign valid_id       = valid_id_q;
  assign fetch_error_id = err_id_q;
  assign pred_taken_id  = pred_id_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequencing, stall, redirect, HALT on fault, reset, optional BTB.
// Inputs change 1ns after the rising edge; outputs are checked there as well.
// icache_error models a 4KB memory: faults on out-of-range or misaligned pc_fetch.

module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  PipeControl  pipe;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        icache_error;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] pc_fetch;
  logic [31:0] pc_id;
  logic        valid_id;
  logic        fetch_error_id;
  logic        pred_taken_id;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .pipe           (pipe),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .icache_error   (icache_error),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .pc_fetch       (pc_fetch),
    .pc_id          (pc_id),
    .valid_id       (valid_id),
    .fetch_error_id (fetch_error_id),
    .pred_taken_id  (pred_taken_id)
  );

  always #5 clk = ~clk;

  assign icache_error = (pc_fetch >= 32'h0000_1000) || (pc_fetch[1:0] != 2'b00);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks pc_fetch, pc_id, valid_id, fetch_error_id, pred_taken_id together.
  task automatic chk_all(input string tag, input logic [31:0] pcf, input logic [31:0] pci,
                         input logic v, input logic e, input logic p);
    chk({tag, ".pc_fetch"}, pc_fetch, pcf);
    chk({tag, ".pc_id"}, pc_id, pci);
    chk({tag, ".valid_id"}, {31'h0, valid_id}, {31'h0, v});
    chk({tag, ".err_id"}, {31'h0, fetch_error_id}, {31'h0, e});
    chk({tag, ".pred_id"}, {31'h0, pred_taken_id}, {31'h0, p});
  endtask

  task automatic redirect(input logic [31:0] tgt, input logic flush, input logic stall);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    pipe.flush     = flush;
    pipe.stall     = stall;
    step();
    redirect_valid = 1'b0;
    pipe.flush     = 1'b0;
    pipe.stall     = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    pipe           = '0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    upd_valid      = 1'b0;
    upd_pc         = 32'h0;
    upd_target     = 32'h0;
    upd_taken      = 1'b0;

    // Reset and sequential fetch.
    step();
    chk_all("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); chk_all("seq1", 32'h4, 32'h0, 1'b1, 1'b0, 1'b0);
    step(); chk_all("seq2", 32'h8, 32'h4, 1'b1, 1'b0, 1'b0);

    // Stall two cycles at pc 0x8.
    pipe.stall = 1'b1;
    step(); chk_all("stall1", 32'h8, 32'h4, 1'b1, 1'b0, 1'b0);
    step(); chk_all("stall2", 32'h8, 32'h4, 1'b1, 1'b0, 1'b0);
    pipe.stall = 1'b0;
    step(); chk_all("resume", 32'hC, 32'h8, 1'b1, 1'b0, 1'b0);
    step(); chk("seq3.pc_fetch", pc_fetch, 32'h10);

    // Redirect with flush at pc 0x10.
    redirect(32'h100, 1'b1, 1'b0);
    chk_all("redir", 32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
    step(); chk_all("redir_next", 32'h104, 32'h100, 1'b1, 1'b0, 1'b0);

    // Redirect together with stall: PC moves, IF/ID untouched.
    redirect(32'h40, 1'b0, 1'b1);
    chk_all("redir_stall", 32'h40, 32'h100, 1'b1, 1'b0, 1'b0);
    step(); chk_all("redir_stall_next", 32'h44, 32'h40, 1'b1, 1'b0, 1'b0);

    // Run off the end of memory into HALT.
    redirect(32'hFFC, 1'b1, 1'b0);
    chk("to_ffc.pc_fetch", pc_fetch, 32'hFFC);
    step(); chk_all("at_1000", 32'h1000, 32'hFFC, 1'b1, 1'b0, 1'b0);
    step(); chk_all("fault", 32'h1004, 32'h1000, 1'b1, 1'b1, 1'b0);
    step(); chk_all("halt1", 32'h1004, 32'h1004, 1'b0, 1'b0, 1'b0);
    step(); chk_all("halt2", 32'h1004, 32'h1004, 1'b0, 1'b0, 1'b0);
    redirect(32'h200, 1'b1, 1'b0);
    chk_all("unhalt", 32'h200, 32'h0, 1'b0, 1'b0, 1'b0);
    step(); chk_all("unhalt_next", 32'h204, 32'h200, 1'b1, 1'b0, 1'b0);

    // Fault seen under stall is ignored, then taken once the stall drops.
    redirect(32'h1000, 1'b1, 1'b0);
    pipe.stall = 1'b1;
    step(); chk_all("fault_stall", 32'h1000, 32'h0, 1'b0, 1'b0, 1'b0);
    pipe.stall = 1'b0;
    step(); chk_all("fault_late", 32'h1004, 32'h1000, 1'b1, 1'b1, 1'b0);

    // Reset mid-operation from HALT, with stall and redirect asserted.
    rst            = 1'b1;
    pipe.stall     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step(); chk_all("mid_rst", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst            = 1'b0;
    pipe.stall     = 1'b0;
    redirect_valid = 1'b0;
    step(); chk_all("post_rst", 32'h4, 32'h0, 1'b1, 1'b0, 1'b0);

`ifdef FETCH_BTB_EN
    // Install 0x8 -> 0x40 and refetch from 0.
    upd_valid  = 1'b1;
    upd_pc     = 32'h8;
    upd_target = 32'h40;
    upd_taken  = 1'b1;
    step();
    upd_valid = 1'b0;
    redirect(32'h0, 1'b1, 1'b0);
    chk("btb0.pc_fetch", pc_fetch, 32'h0);
    step(); chk("btb1.pc_fetch", pc_fetch, 32'h4);
    step(); chk("btb2.pc_fetch", pc_fetch, 32'h8);
    step(); chk_all("btb_hit", 32'h40, 32'h8, 1'b1, 1'b0, 1'b1);
    // Invalidate and refetch: plain sequential again.
    upd_valid = 1'b1;
    upd_taken = 1'b0;
    redirect(32'h0, 1'b1, 1'b0);
    upd_valid = 1'b0;
    step(); step();
    chk("btb_inv8.pc_fetch", pc_fetch, 32'h8);
    step(); chk_all("btb_inv", 32'hC, 32'h8, 1'b1, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
